// File: rtl/add_pipe.sv
// add_pipe: pipelined ripple-chunk adder/subtractor, one CHUNK-bit carry chain per stage.
// Define ADD_OVF_EN to add the registered signed-overflow output ovf.
module add_pipe #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic [WIDTH-1:0] Y,
   output logic             Cout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int STAGES = WIDTH / CHUNK;

   if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_param_check
      $error("add_pipe: WIDTH must be a positive multiple of CHUNK");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_bx;

   assign w_bx = sub ? ~B : B;

   // Stage k adds chunk k; r_lo holds the finished low chunks, g_pend the operand bits still to add.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int DONE_W = (k + 1) * CHUNK;
      localparam int PEND_W = WIDTH - DONE_W;

      logic [CHUNK-1:0]  w_ca;
      logic [CHUNK-1:0]  w_cb;
      logic              w_ci;
      logic              w_vi;
      logic [CHUNK:0]    w_add;
      logic [DONE_W-1:0] w_lo_nx;
      logic [DONE_W-1:0] r_lo;
      logic              r_c;
      logic              r_v;

      if (k == 0) begin : g_src
         assign w_ca    = A[CHUNK-1:0];
         assign w_cb    = w_bx[CHUNK-1:0];
         assign w_ci    = Cin;
         assign w_vi    = in_valid;
         assign w_lo_nx = w_add[CHUNK-1:0];
      end else begin : g_src
         assign w_ca    = g_stage[k-1].g_pend.r_ah[CHUNK-1:0];
         assign w_cb    = g_stage[k-1].g_pend.r_bh[CHUNK-1:0];
         assign w_ci    = g_stage[k-1].r_c;
         assign w_vi    = g_stage[k-1].r_v;
         assign w_lo_nx = {w_add[CHUNK-1:0], g_stage[k-1].r_lo};
      end

      assign w_add = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, w_ci};

      always_ff @(posedge clk) begin
         if (rst) begin
            r_v  <= 1'b0;
            r_c  <= 1'b0;
            r_lo <= '0;
         end else if (w_adv) begin
            r_v  <= w_vi;
            r_c  <= w_add[CHUNK];
            r_lo <= w_lo_nx;
         end
      end

      if (PEND_W > 0) begin : g_pend
         logic [PEND_W-1:0] w_ah_nx;
         logic [PEND_W-1:0] w_bh_nx;
         logic [PEND_W-1:0] r_ah;
         logic [PEND_W-1:0] r_bh;

         if (k == 0) begin : g_nx
            assign w_ah_nx = A[WIDTH-1:CHUNK];
            assign w_bh_nx = w_bx[WIDTH-1:CHUNK];
         end else begin : g_nx
            assign w_ah_nx = g_stage[k-1].g_pend.r_ah[PEND_W+CHUNK-1:CHUNK];
            assign w_bh_nx = g_stage[k-1].g_pend.r_bh[PEND_W+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_ah <= '0;
               r_bh <= '0;
            end else if (w_adv) begin
               r_ah <= w_ah_nx;
               r_bh <= w_bh_nx;
            end
         end
      end
   end

   assign Y         = g_stage[STAGES-1].r_lo;
   assign Cout      = g_stage[STAGES-1].r_c;
   assign out_valid = g_stage[STAGES-1].r_v;
   assign in_ready  = !out_valid || out_ready;
   assign w_adv     = in_ready;

`ifdef ADD_OVF_EN
   // Operand sign bits are the MSBs of the top chunk, consumed by the last stage.
   logic w_sa;
   logic w_sb;
   logic w_sy;
   logic r_ovf;

   assign w_sa = g_stage[STAGES-1].w_ca[CHUNK-1];
   assign w_sb = g_stage[STAGES-1].w_cb[CHUNK-1];
   assign w_sy = g_stage[STAGES-1].w_add[CHUNK-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ovf <= (w_sa == w_sb) && (w_sy != w_sa);
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined ripple-chunk adder/subtractor, the successor of the fixed 16-bit combinational adder. It splits a WIDTH-bit add into STAGES = WIDTH/CHUNK registered chunk additions, so the carry chain is one CHUNK long per cycle. It uses a valid/ready handshake with output backpressure. It sits in the arithmetic datapath wherever a wide add must close timing at full clock rate.

## Interface
- WIDTH, 16, operand/result width; WIDTH % CHUNK == 0 is required (elaboration error otherwise)
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (default 4)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand set on A/B/Cin/sub is valid
- in_ready  output  1  pipeline can accept; in_ready = !out_valid || out_ready (combinational)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry in
- sub  input  1  0: A + B + Cin; 1: A + ~B + Cin (Cin=1 gives A − B)
- Y  output  WIDTH  registered sum
- Cout  output  1  registered carry out of bit WIDTH−1
- out_valid  output  1  Y/Cout hold a result
- out_ready  input  1  downstream accepts result this cycle
- ovf  output  1  signed overflow (only with ADD_OVF_EN)

## Operation
- Accept: transfer when in_valid && in_ready; B is inverted at acceptance when sub=1.
- Stage k (0..STAGES−1) adds chunk k of A/B' plus the carry registered by stage k−1 (stage 0 uses Cin); completed low chunks and not-yet-added high chunks travel in skew registers alongside.
- Each stage carries its own valid bit; bubbles (accept without in_valid) propagate as invalid.
- Global advance enable = in_ready; when 0, every stage, skew register and valid bit holds.
- Final stage writes Y, Cout, out_valid (and ovf).
- Results leave in acceptance order; none dropped or duplicated under any out_ready pattern.
- Arithmetic: {Cout,Y} = A + B' + Cin modulo 2^(WIDTH+1); no saturation.
- Reset (any cycle, including mid-stream): all valid bits 0, all in-flight operands discarded, Y=0, Cout=0, ovf=0, out_valid=0; hence in_ready=1 in the cycle after reset.

## Timing
- Latency: operand accepted at edge n → out_valid=1 with its result after edge n+STAGES (default 4 cycles).
- Throughput: one result per cycle while out_ready=1.
- Stall: out_valid && !out_ready → in_ready=0, Y/Cout/ovf/out_valid stable, in_valid ignored.
- out_valid && out_ready with a valid result behind it → next result presented the following cycle (no bubble).
- in_valid while in_ready=0 has no effect; source must hold its data.
- STAGES=1 (CHUNK=WIDTH) is legal: single registered adder, latency 1.

## Configuration
- ADD_OVF_EN defined: ovf port present; ovf = (A[W−1] == B'[W−1]) && (Y[W−1] != A[W−1]), computed from the operand sign bits carried through the pipeline and registered with Y; reset 0.
- ADD_OVF_EN undefined: no ovf port, no sign-bit skew registers; all other behaviour identical.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → Y=0x0000, Cout=0, out_valid=0, in_ready=1; nothing emerges afterwards.
- Single add: A=0xFFFF, B=0xFFFF, Cin=1, sub=0 → 4 cycles later Y=0xFFFF, Cout=1, out_valid=1.
- Back-to-back: 0x0000+0x0000+1, 0xFFFF+0x0000+1, 0x1234+0x4321+0 on consecutive cycles → consecutive outputs 0x0001/0, 0x0000/1, 0x5555/0 on cycles 4, 5, 6.
- Subtract: A=0x0005, B=0x0007, sub=1, Cin=1 → Y=0xFFFE, Cout=0; A=0x0007, B=0x0005 → Y=0x0002, Cout=1.
- Backpressure: stream of 6 adds with out_ready low for 3 cycles mid-stream → Y held, in_ready=0 during stall, all 6 results in order, none lost; rst asserted mid-stream with 3 results in flight → none emerge.
- ADD_OVF_EN: 0x7FFF+0x0001 → Y=0x8000, ovf=1; 0x8000+0x8000 → Y=0x0000, Cout=1, ovf=1; 0x0001+0x0001 → ovf=0.
